// File: rtl/mmio_key_sw_dev.sv
// Memory-mapped key/switch device: synchronised, debounced board inputs with per-channel Ready/Overrun/IE.
// Define MMIO_KEY_SW_IRQ_EN to enable the interrupt output and the IE bits.

module mmio_key_sw_dev #(
  parameter int unsigned      DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SDATA      = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114,
  parameter int unsigned      DEBOUNCE_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             rdEn,
  input  logic             wrtEn,
  input  logic [DBITS-1:0] dIn,
  output logic [DBITS-1:0] dOut,
  output logic             hit,
  input  logic [3:0]       key,
  input  logic [9:0]       sw,
  output logic             intr
);

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  // Bus strobes: rdEn and wrtEn are single-cycle strobes qualified by addr, with no
  // backpressure; a strobe takes effect at the rising edge during which it is high.
  logic k_rd, s_rd, k_wr, s_wr;
  assign k_rd = rdEn  && (addr == ADDR_KDATA);
  assign s_rd = rdEn  && (addr == ADDR_SDATA);
  assign k_wr = wrtEn && (addr == ADDR_KCTRL);
  assign s_wr = wrtEn && (addr == ADDR_SCTRL);

  assign hit = (addr == ADDR_KDATA) || (addr == ADDR_SDATA) ||
               (addr == ADDR_KCTRL) || (addr == ADDR_SCTRL);

  // ---------------- key channel: sync, debounce ----------------
  logic [3:0]  key_s1, key_s2, key_deb;
  logic [15:0] key_cnt;
  logic        key_chg;

  assign key_chg = (key_s2 != key_deb) && (key_cnt == DB_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1  <= 4'hF;
      key_s2  <= 4'hF;
      key_deb <= 4'hF;
      key_cnt <= '0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
      if (key_s2 == key_deb) begin
        key_cnt <= '0;
      end else if (key_chg) begin
        key_deb <= key_s2;
        key_cnt <= '0;
      end else begin
        key_cnt <= key_cnt + 16'd1;
      end
    end
  end

  // ---------------- switch channel: sync, debounce ----------------
  logic [9:0]  sw_s1, sw_s2, sw_deb;
  logic [15:0] sw_cnt;
  logic        sw_chg;

  assign sw_chg = (sw_s2 != sw_deb) && (sw_cnt == DB_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      sw_deb <= '0;
      sw_cnt <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      if (sw_s2 == sw_deb) begin
        sw_cnt <= '0;
      end else if (sw_chg) begin
        sw_deb <= sw_s2;
        sw_cnt <= '0;
      end else begin
        sw_cnt <= sw_cnt + 16'd1;
      end
    end
  end

  // ---------------- status bits ----------------
  // A data change in the same cycle as a data read wins: Ready stays set and the
  // read is not treated as having missed anything, so Overrun is not raised.
  logic k_ready, k_ovr, s_ready, s_ovr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_ready <= 1'b0;
      k_ovr   <= 1'b0;
    end else begin
      if (key_chg)   k_ready <= 1'b1;
      else if (k_rd) k_ready <= 1'b0;
      if (key_chg && k_ready && !k_rd) k_ovr <= 1'b1;
      else if (k_wr && !dIn[2])        k_ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ready <= 1'b0;
      s_ovr   <= 1'b0;
    end else begin
      if (sw_chg)    s_ready <= 1'b1;
      else if (s_rd) s_ready <= 1'b0;
      if (sw_chg && s_ready && !s_rd) s_ovr <= 1'b1;
      else if (s_wr && !dIn[2])       s_ovr <= 1'b0;
    end
  end

  // ---------------- interrupt enable / request ----------------
  logic k_ie, s_ie;

`ifdef MMIO_KEY_SW_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_ie <= 1'b0;
      s_ie <= 1'b0;
      intr <= 1'b0;
    end else begin
      if (k_wr) k_ie <= dIn[8];
      if (s_wr) s_ie <= dIn[8];
      intr <= (k_ready & k_ie) | (s_ready & s_ie);
    end
  end

  logic unused_din;
  assign unused_din = ^{dIn[DBITS-1:9], dIn[7:3], dIn[1:0]};
`else
  assign k_ie = 1'b0;
  assign s_ie = 1'b0;
  assign intr = 1'b0;

  logic unused_din;
  assign unused_din = ^{dIn[DBITS-1:9], dIn[8], dIn[7:3], dIn[1:0]};
`endif

  // ---------------- read mux ----------------
  logic [DBITS-1:0] kdata, sdata, kctrl, sctrl;

  always_comb begin
    kdata      = '0;
    kdata[3:0] = ~key_deb;
    sdata      = '0;
    sdata[9:0] = sw_deb;
    kctrl      = '0;
    kctrl[0]   = k_ready;
    kctrl[2]   = k_ovr;
    kctrl[8]   = k_ie;
    sctrl      = '0;
    sctrl[0]   = s_ready;
    sctrl[2]   = s_ovr;
    sctrl[8]   = s_ie;
  end

  always_comb begin
    dOut = '0;
    if (addr == ADDR_KDATA)      dOut = kdata;
    else if (addr == ADDR_SDATA) dOut = sdata;
    else if (addr == ADDR_KCTRL) dOut = kctrl;
    else if (addr == ADDR_SCTRL) dOut = sctrl;
  end

endmodule

// File: tb/tb_mmio_key_sw_dev.sv
// Bench for mmio_key_sw_dev: directed scenarios plus randomized bus/input traffic,
// checked every cycle against a behavioural model of the register rules.

module tb_mmio_key_sw_dev;

  localparam int          DB     = 4;
  localparam logic [31:0] KDATA  = 32'hF0000010;
  localparam logic [31:0] SDATA  = 32'hF0000014;
  localparam logic [31:0] KCTRL  = 32'hF0000110;
  localparam logic [31:0] SCTRL  = 32'hF0000114;
`ifdef MMIO_KEY_SW_IRQ_EN
  localparam logic        IRQ_ON = 1'b1;
`else
  localparam logic        IRQ_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] addr = '0;
  logic        rdEn = 1'b0;
  logic        wrtEn = 1'b0;
  logic [31:0] dIn = '0;
  logic [31:0] dOut;
  logic        hit;
  logic [3:0]  key = 4'hF;
  logic [9:0]  sw = '0;
  logic        intr;

  mmio_key_sw_dev #(
    .DBITS(32), .ADDR_KDATA(KDATA), .ADDR_SDATA(SDATA),
    .ADDR_KCTRL(KCTRL), .ADDR_SCTRL(SCTRL), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .rdEn(rdEn), .wrtEn(wrtEn),
    .dIn(dIn), .dOut(dOut), .hit(hit), .key(key), .sw(sw), .intr(intr)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_khist[$];
  logic [9:0] m_shist[$];
  logic [3:0] m_kdeb;
  logic [9:0] m_sdeb;
  int         m_krun, m_srun;
  logic       m_kready, m_kovr, m_kie, m_sready, m_sovr, m_sie, m_intr;

  task automatic model_reset();
    m_khist  = '{4'hF, 4'hF};
    m_shist  = '{10'h0, 10'h0};
    m_kdeb   = 4'hF;
    m_sdeb   = '0;
    m_krun   = 0;
    m_srun   = 0;
    m_kready = 0; m_kovr = 0; m_kie = 0;
    m_sready = 0; m_sovr = 0; m_sie = 0;
    m_intr   = 0;
  endtask

  function automatic logic [31:0] exp_dout(input logic [31:0] a);
    if (a == KDATA) return {28'b0, ~m_kdeb};
    if (a == SDATA) return {22'b0, m_sdeb};
    if (a == KCTRL) return {23'b0, m_kie, 5'b0, m_kovr, 1'b0, m_kready};
    if (a == SCTRL) return {23'b0, m_sie, 5'b0, m_sovr, 1'b0, m_sready};
    return '0;
  endfunction

  task automatic chan(input logic chg, input logic rd, input logic wr,
                      inout logic rdy, inout logic ovr, inout logic ie);
    logic was_rdy;
    was_rdy = rdy;
    if (wr && !dIn[2]) ovr = 1'b0;
    if (chg && was_rdy && !rd) ovr = 1'b1;
    if (chg) rdy = 1'b1;
    else if (rd) rdy = 1'b0;
    if (IRQ_ON && wr) ie = dIn[8];
  endtask

  // One rising edge: the input seen by the debouncer is the raw value from two edges ago;
  // a new value is accepted once it has differed from the debounced value DB cycles running.
  task automatic model_edge();
    logic [3:0] ks;
    logic [9:0] ss;
    logic kchg, schg, nintr;
    ks = m_khist.pop_front();
    m_khist.push_back(key);
    ss = m_shist.pop_front();
    m_shist.push_back(sw);
    m_krun = (ks != m_kdeb) ? m_krun + 1 : 0;
    m_srun = (ss != m_sdeb) ? m_srun + 1 : 0;
    kchg = (m_krun == DB);
    schg = (m_srun == DB);
    nintr = (m_kready & m_kie) | (m_sready & m_sie);
    chan(kchg, rdEn && addr == KDATA, wrtEn && addr == KCTRL, m_kready, m_kovr, m_kie);
    chan(schg, rdEn && addr == SDATA, wrtEn && addr == SCTRL, m_sready, m_sovr, m_sie);
    if (kchg) begin m_kdeb = ks; m_krun = 0; end
    if (schg) begin m_sdeb = ss; m_srun = 0; end
    m_intr = IRQ_ON ? nintr : 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d);
    addr = a; rdEn = r; wrtEn = w; dIn = d;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    exp_q.push_back(exp_dout(addr));
    #1;
    check("dout", dOut, exp_q.pop_front());
    check("hit", {31'b0, hit}, {31'b0, (addr == KDATA) || (addr == SDATA) ||
                                       (addr == KCTRL) || (addr == SCTRL)});
    check("intr", {31'b0, intr}, {31'b0, m_intr});
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic peek_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus(a, 1'b0, 1'b0, '0);
    #1;
    check(tag, dOut, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(negedge clk);
    cycles(2);
    peek_check("rst_kdata", KDATA, 32'h0);
    peek_check("rst_kctrl", KCTRL, 32'h0);
    check("rst_intr", {31'b0, intr}, 32'h0);
    reset = 1'b0;
    bus('0, 0, 0, '0);
    cycles(3);

    // Glitch shorter than the debounce window is rejected.
    key = 4'hE;
    cycles(3);
    key = 4'hF;
    cycles(6);
    peek_check("glitch_kdata", KDATA, 32'h0);
    peek_check("glitch_kctrl", KCTRL, 32'h0);

    // Stable press accepted after 2 + DB edges; read clears Ready.
    key = 4'hE;
    bus('0, 0, 0, '0);
    cycles(5);
    peek_check("press_early", KDATA, 32'h0);
    cycles(1);
    peek_check("press_kdata", KDATA, 32'h1);
    peek_check("press_kctrl", KCTRL, 32'h1);
    bus(KDATA, 1, 0, '0);
    #1 check("press_read", dOut, 32'h1);
    cycle();
    peek_check("press_clr", KCTRL, 32'h0);

    // Two switch changes without a read -> Overrun; write 0 clears it.
    sw = 10'h3FF;
    bus('0, 0, 0, '0);
    cycles(7);
    sw = 10'h001;
    cycles(7);
    peek_check("sw_data", SDATA, 32'h1);
    peek_check("sw_ovr", SCTRL, 32'h5);
    bus(SCTRL, 0, 1, 32'h0);
    cycle();
    peek_check("sw_ovr_clr", SCTRL, 32'h1);

    // Data read in the very cycle the debounced key changes.
    key = 4'hF;
    bus('0, 0, 0, '0);
    cycles(7);
    key = 4'hE;
    cycles(5);
    bus(KDATA, 1, 0, '0);
    #1 check("race_old", dOut, 32'h0);
    cycle();
    bus('0, 0, 0, '0);
    peek_check("race_kctrl", KCTRL, 32'h1);
    peek_check("race_kdata", KDATA, 32'h1);

    // Interrupt path.
    key = 4'hF;
    bus('0, 0, 0, '0);
    cycles(7);
    bus(KDATA, 1, 0, '0);
    cycle();
    bus(KCTRL, 0, 1, 32'h100);
    cycle();
    peek_check("ie_set", KCTRL, IRQ_ON ? 32'h100 : 32'h0);
    key = 4'hB;
    bus('0, 0, 0, '0);
    cycles(6);
    check("irq_wait", {31'b0, intr}, 32'h0);
    peek_check("irq_ready", KCTRL, IRQ_ON ? 32'h101 : 32'h1);
    bus('0, 0, 0, '0);
    cycle();
    check("irq_on", {31'b0, intr}, {31'b0, IRQ_ON});
    bus(KDATA, 1, 0, '0);
    #1 check("irq_kdata", dOut, 32'h4);
    cycle();
    bus('0, 0, 0, '0);
    cycle();
    check("irq_off", {31'b0, intr}, 32'h0);

    // Asynchronous reset mid-debounce.
    sw = 10'h2AA;
    cycles(3);
    #2 reset = 1'b1;
    model_reset();
    peek_check("arst_kdata", KDATA, 32'h0);
    peek_check("arst_sdata", SDATA, 32'h0);
    peek_check("arst_kctrl", KCTRL, 32'h0);
    peek_check("arst_sctrl", SCTRL, 32'h0);
    check("arst_intr", {31'b0, intr}, 32'h0);
    sw = 10'h0;
    key = 4'hF;
    @(negedge clk);
    cycles(2);
    reset = 1'b0;
    cycles(10);
    peek_check("post_sctrl", SCTRL, 32'h0);
    peek_check("post_sdata", SDATA, 32'h0);
    peek_check("post_kctrl", KCTRL, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) key = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) sw = 10'($urandom_range(0, 1023));
      case ($urandom_range(0, 5))
        0: a = KDATA;
        1: a = SDATA;
        2: a = KCTRL;
        3: a = SCTRL;
        4: a = $urandom;
        default: a = SCTRL + 32'h4;
      endcase
      bus(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_key_sw_dev.md
MMIO_KEY_SW_DEV -- requirements
Module: mmio_key_sw_dev

Interface
REQ-001 SHALL have parameter DBITS, default 32, data/address bus width.
REQ-002 SHALL have parameter ADDR_KDATA, default 32'hF0000010, key data register address.
REQ-003 SHALL have parameter ADDR_SDATA, default 32'hF0000014, switch data register address.
REQ-004 SHALL have parameter ADDR_KCTRL, default 32'hF0000110, key control/status register address.
REQ-005 SHALL have parameter ADDR_SCTRL, default 32'hF0000114, switch control/status register address.
REQ-006 SHALL have parameter DEBOUNCE_CYCLES, default 10, stable-cycle count required before accepting an input change (range 1..65535).
REQ-007 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-009 SHALL have port addr, input, DBITS, bus address from the processor memory stage.
REQ-010 SHALL have port rdEn, input, 1, read strobe that qualifies read side effects.
REQ-011 SHALL have port wrtEn, input, 1, write strobe.
REQ-012 SHALL have port dIn, input, DBITS, write data.
REQ-013 SHALL have port dOut, output, DBITS, read data.
REQ-014 SHALL have port hit, output, 1, high when addr matches any of the four register addresses.
REQ-015 SHALL have port key, input, 4, raw board keys, active-low.
REQ-016 SHALL have port sw, input, 10, raw board switches.
REQ-017 SHALL have port intr, output, 1, interrupt request.

Function
REQ-018 SHALL pass key and sw through a two-flop synchronizer before any other use.
REQ-019 SHALL update the debounced value of each input group (KEY, SW) only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any reversion during the count SHALL restart the count from zero.
REQ-020 SHALL store KDATA as the inverted debounced key (1 = pressed) in bits [3:0], with zeros above; SDATA SHALL hold debounced sw in [9:0], with zeros above.
REQ-021 SHALL define each CTRL register as: bit0 Ready (read-only), bit2 Overrun, bit8 IE; all other bits read 0.
REQ-022 SHALL set Ready in the cycle the corresponding debounced value changes; if Ready is already 1 at that edge, it SHALL also set Overrun.
REQ-023 SHALL clear Ready on the clock edge where rdEn=1 and addr equals the corresponding DATA address.
REQ-024 SHALL give priority to a simultaneous data change and DATA read: Ready stays 1, Overrun is not set, and dOut returns the pre-change value.
REQ-025 SHALL clear Overrun on a CTRL write with dIn[2]=0; a write with dIn[2]=1 SHALL leave it unchanged; writes SHALL never set Overrun.
REQ-026 SHALL load IE from dIn[8] on a CTRL write.
REQ-027 SHALL ignore writes to DATA addresses and to unmapped addresses.
REQ-028 SHALL drive dOut combinationally (zero-latency, same cycle as addr) with the addressed register, and 0 when hit=0.
REQ-029 SHALL apply the rules in REQ-022 to REQ-026 independently to the KEY and SW channels in every cycle.

Reset
REQ-030 SHALL, while reset=1, force synchronizers, debounced values, and counters to their idle values (key=released, sw=0), KDATA=0, SDATA=0, Ready=0, Overrun=0, IE=0, and intr=0.
REQ-031 SHALL, when reset asserts mid-debounce, discard the pending count, and SHALL not set Ready for any value captured before the release of reset.

Configuration
REQ-032 SHALL, when macro MMIO_KEY_SW_IRQ_EN is defined, drive intr registered as (KCTRL.Ready & KCTRL.IE) | (SCTRL.Ready & SCTRL.IE), one cycle after the condition is met.
REQ-033 SHALL, when MMIO_KEY_SW_IRQ_EN is undefined, tie intr to 0, make IE read 0, and ignore writes to IE.

Verification
REQ-034 SHALL be tested as follows: with DEBOUNCE_CYCLES=4, hold key=4'b1110 for 3 cycles then return to 1111 -> KDATA stays 0 and Ready stays 0.
REQ-035 SHALL be tested as follows: hold key=4'b1110 stably -> KDATA=1 and KCTRL=1 after 2+4 cycles; then rdEn on ADDR_KDATA -> dOut=1 that cycle and KCTRL reads 0 on the next cycle.
REQ-036 SHALL be tested as follows: set sw=10'h3FF, then sw=10'h001 without reading -> SCTRL=32'h5; a write of 0 to SCTRL -> SCTRL=32'h1.
REQ-037 SHALL be tested as follows: issue a KDATA read in the same cycle the debounced key changes -> KCTRL bit0=1, bit2=0, and dOut returns the old value.
REQ-038 SHALL be tested as follows: with MMIO_KEY_SW_IRQ_EN defined, write KCTRL=32'h100 and then press a key -> intr=1 one cycle after Ready; after the KDATA read, intr=0. With the macro undefined, intr=0 throughout.
REQ-039 SHALL be tested as follows: assert reset asynchronously mid-debounce with sw toggled -> all registers read 0 immediately, and no Ready is set after reset is released while the input is unchanged.
